mem_seq_8b: RTL

//  Memory sequencer downstream of the micro-op core: turns 16-bit core memory requests into byte cycles on an 8-bit bus.
//  - Inputs: MAR prepare, start/width/cmd/tag from the core. Splits word accesses into low/high byte cycles, honours bus wait states.
//  - Returns read data tagged by reservation station (t_id) as a one-cycle write pulse; core_busy feeds the core's hold input.

---
 rtl/mem_seq_pkg.sv | 19 +
 rtl/mem_seq_addr_inc.sv | 19 +
 rtl/mem_seq_8b.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared constants for the 8-bit memory sequencer and the core's uop decode.
// State encoding, access width, command and reservation-station tag values.
package mem_seq_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LO   = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic WIDTH_BYTE = 1'b0;
   localparam logic WIDTH_WORD = 1'b1;

   localparam logic CMD_RD = 1'b0;
   localparam logic CMD_WR = 1'b1;

   localparam logic TAG_A = 1'b0;
   localparam logic TAG_B = 1'b1;

endpackage

// File: rtl/mem_seq_addr_inc.sv
// Next-byte address for the high half of a word access.
// MEM_SEQ_PAGE_WRAP_EN selects 6502-style page wrap instead of a full 16-bit carry.
module mem_seq_addr_inc
   import mem_seq_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] addr_next
);

`ifdef MEM_SEQ_PAGE_WRAP_EN
   // Carry out of the low byte is discarded: 0x12FF -> 0x1200.
   assign addr_next = {addr[ADDR_W-1:8], addr[7:0] + 8'd1};
`else
   assign addr_next = addr + ADDR_W'(1);
`endif

endmodule

// File: rtl/mem_seq_8b.sv
// Memory sequencer: splits 16-bit core requests into byte cycles on an 8-bit bus.
// Build option MEM_SEQ_PAGE_WRAP_EN (see mem_seq_addr_inc) changes the high-byte address.
//
// Bus handshake: bus_rd/bus_wr are registered and held, with bus_addr/bus_dout
// stable, until an edge where strobe && bus_ready; that edge completes the byte.
module mem_seq_8b
   import mem_seq_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int BUS_DW = 8
) (
   input  logic              clk,
   input  logic              a_rst,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [15:0]       core_wdata,
   input  logic              core_prep_addr,
   input  logic              core_start,
   input  logic              core_width,
   input  logic              core_cmd,
   input  logic              core_t_id,
   output logic [15:0]       core_rdata,
   output logic              core_rdata_tag,
   output logic              core_rdata_wr,
   output logic              core_busy,
   output logic              core_err,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [BUS_DW-1:0] bus_dout,
   input  logic [BUS_DW-1:0] bus_din,
   output logic              bus_rd,
   output logic              bus_wr,
   input  logic              bus_ready,
   output logic [1:0]        dbg_state
);

   logic [1:0]        state;
   logic [ADDR_W-1:0] mar;
   logic [ADDR_W-1:0] a_q;
   logic [ADDR_W-1:0] a_next;
   logic [ADDR_W-1:0] req_addr;
   logic [15:0]       wdata_q;
   logic              width_q;
   logic              cmd_q;
   logic              tid_q;
   logic              xfer_done;

   // Same-cycle prep+start bypasses MAR so the request sees the new address.
   assign req_addr  = core_prep_addr ? core_addr : mar;
   assign xfer_done = (bus_rd | bus_wr) & bus_ready;
   assign core_busy = (state != ST_IDLE);
   assign dbg_state = state;

   mem_seq_addr_inc #(.ADDR_W(ADDR_W)) u_addr_inc (
      .addr      (a_q),
      .addr_next (a_next)
   );

   always_ff @(posedge clk) begin
      if (a_rst) begin
         state          <= ST_IDLE;
         mar            <= '0;
         a_q            <= '0;
         wdata_q        <= '0;
         width_q        <= WIDTH_BYTE;
         cmd_q          <= CMD_RD;
         tid_q          <= TAG_A;
         core_rdata     <= '0;
         core_rdata_tag <= 1'b0;
         core_rdata_wr  <= 1'b0;
         core_err       <= 1'b0;
         bus_addr       <= '0;
         bus_dout       <= '0;
         bus_rd         <= 1'b0;
         bus_wr         <= 1'b0;
      end else begin
         core_rdata_wr <= 1'b0;
         if (core_prep_addr)
            mar <= core_addr;
         if (core_start && (state != ST_IDLE))
            core_err <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (core_start) begin
                  a_q      <= req_addr;
                  wdata_q  <= core_wdata;
                  width_q  <= core_width;
                  cmd_q    <= core_cmd;
                  tid_q    <= core_t_id;
                  bus_addr <= req_addr;
                  bus_dout <= core_wdata[7:0];
                  bus_rd   <= (core_cmd == CMD_RD);
                  bus_wr   <= (core_cmd == CMD_WR);
                  if ((core_cmd == CMD_RD) && (core_width == WIDTH_BYTE))
                     core_rdata[15:8] <= 8'h00;
                  state    <= ST_LO;
               end
            end
            ST_LO: begin
               if (xfer_done) begin
                  if (cmd_q == CMD_RD)
                     core_rdata[7:0] <= bus_din;
                  if (width_q == WIDTH_WORD) begin
                     bus_addr <= a_next;
                     bus_dout <= wdata_q[15:8];
                     state    <= ST_HI;
                  end else begin
                     bus_rd        <= 1'b0;
                     bus_wr        <= 1'b0;
                     core_rdata_wr <= (cmd_q == CMD_RD);
                     if (cmd_q == CMD_RD)
                        core_rdata_tag <= tid_q;
                     state         <= ST_DONE;
                  end
               end
            end
            ST_HI: begin
               if (xfer_done) begin
                  if (cmd_q == CMD_RD) begin
                     core_rdata[15:8] <= bus_din;
                     core_rdata_tag   <= tid_q;
                  end
                  bus_rd        <= 1'b0;
                  bus_wr        <= 1'b0;
                  core_rdata_wr <= (cmd_q == CMD_RD);
                  state         <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
